// File: rtl/alu_seq_unit_if.sv
// Request/response bundle for alu_seq_unit: operand request channel, result
// channel with status flags, and the FSM state for observation.
interface alu_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       aluop;
  logic [5:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             div_by_zero;
  logic             illegal;
  logic             busy;
  logic [1:0]       state;

  modport master (
    output in_valid, aluop, func, a, b, out_ready,
    input  in_ready, out_valid, result, zero, div_by_zero, illegal, busy, state
  );

  modport slave (
    input  in_valid, aluop, func, a, b, out_ready,
    output in_ready, out_valid, result, zero, div_by_zero, illegal, busy, state
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle ADD/SUB/AND/OR/SLT/NOP plus iterative
// shift-add multiply and restoring divide, one result held until consumed.
module alu_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_seq_unit_if.slave bus
);

  // Handshake: a request is taken on a rising edge where in_valid & in_ready;
  // a result is taken on a rising edge where out_valid & out_ready. Neither
  // side may depend on the other's ready to raise its own valid.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SLT,
    OP_MUL,
    OP_DIV,
    OP_NOP,
    OP_ILL
  } op_t;

  state_t state_q, state_d, dest_state;
  op_t    op;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, dbz_q, ill_q;

  logic             accept;
  logic             last_step;
  logic             b_zero;
  logic             slt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_dbz, sc_ill;
  logic [WIDTH-1:0] mul_next;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_next, quo_next;

  assign accept    = bus.in_valid & bus.in_ready;
  assign last_step = (cnt_q == CW'(WIDTH - 1));
  assign b_zero    = (bus.b == '0);
  assign slt       = ($signed(bus.a) < $signed(bus.b));

  always_comb begin
    op = OP_ILL;
    case (bus.aluop)
      3'b000: op = OP_ADD;
      3'b001: op = OP_SLT;
      3'b100: op = OP_AND;
      3'b011: op = OP_OR;
      3'b010: begin
        case (bus.func)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b101010: op = OP_SLT;
          6'b011000: op = OP_MUL;
          6'b011010: op = OP_DIV;
          6'b000000: op = OP_NOP;
          default:   op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

  // Results that are known at accept time, including divide-by-zero.
  always_comb begin
    sc_res = '0;
    sc_dbz = 1'b0;
    sc_ill = 1'b0;
    case (op)
      OP_ADD: sc_res = bus.a + bus.b;
      OP_SUB: sc_res = bus.a - bus.b;
      OP_AND: sc_res = bus.a & bus.b;
      OP_OR:  sc_res = bus.a | bus.b;
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, slt};
      OP_DIV: begin
        if (b_zero) begin
          sc_res = '1;
          sc_dbz = 1'b1;
        end
      end
      OP_ILL:  sc_ill = 1'b1;
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    dest_state = S_DONE;
    if (op == OP_MUL) begin
      dest_state = S_MUL;
    end else if ((op == OP_DIV) && !b_zero) begin
      dest_state = S_DIV;
    end
  end

  assign mul_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, dvsr_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_next  = {quo_q[WIDTH-2:0], div_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) state_d = dest_state;
      end
      S_MUL, S_DIV: begin
        if (last_step) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = bus.in_valid ? dest_state : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    bus.busy        = 1'b0;
    bus.state       = state_q;
    bus.result      = result_q;
    bus.zero        = zero_q;
    bus.div_by_zero = dbz_q;
    bus.illegal     = ill_q;
    case (state_q)
      S_IDLE: bus.in_ready = 1'b1;
      S_MUL,
      S_DIV:  bus.busy = 1'b1;
      S_DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  // Datapath: iteration registers load at accept; the result registers load
  // either at accept (single-cycle) or on the final iteration step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
      if (dest_state == S_MUL) begin
        acc_q    <= '0;
        mcand_q  <= bus.a;
        mplier_q <= bus.b;
      end else if (dest_state == S_DIV) begin
        rem_q  <= '0;
        quo_q  <= bus.a;
        dvsr_q <= bus.b;
      end else begin
        result_q <= sc_res;
        zero_q   <= (sc_res == '0);
        dbz_q    <= sc_dbz;
        ill_q    <= sc_ill;
      end
    end else begin
      case (state_q)
        S_MUL: begin
          acc_q    <= mul_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= last_step ? '0 : cnt_q + 1'b1;
          if (last_step) begin
            result_q <= mul_next;
            zero_q   <= (mul_next == '0);
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
          end
        end
        S_DIV: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= last_step ? '0 : cnt_q + 1'b1;
          if (last_step) begin
            result_q <= quo_next;
            zero_q   <= (quo_next == '0);
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
          end
        end
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: hand-computed results, latency, busy
// duration, backpressure, back-to-back accept and mid-operation reset.
module tb_alu_seq_unit;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  alu_seq_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_seq_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for its result (bounded), check it, consume it.
  task automatic run_op(input string tag, input logic [2:0] aluop, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_dbz,
                        input logic exp_ill, input int exp_lat);
    int lat;
    int busy_n;
    int guard;
    logic [31:0] exp_r;
    bus.aluop     = aluop;
    bus.func      = fn;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    exp_q.push_back(exp_res);
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy) begin
        busy_n++;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.aluop = 3'($urandom_range(0, 7));
        bus.func  = 6'($urandom_range(0, 63));
      end
      @(posedge clk); #1;
      lat++;
    end
    exp_r = exp_q.pop_front();
    chk({tag, ".lat"}, lat, exp_lat);
    if (exp_lat > 1) chk({tag, ".busy_cycles"}, busy_n, exp_lat - 1);
    chk({tag, ".result"}, bus.result, exp_r);
    chk({tag, ".zero"}, bus.zero, (exp_r == 0));
    chk({tag, ".dbz"}, bus.div_by_zero, exp_dbz);
    chk({tag, ".ill"}, bus.illegal, exp_ill);
    @(posedge clk); #1;
    chk({tag, ".consumed"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.aluop     = 3'b000;
    bus.func      = 6'b000000;
    bus.a         = '0;
    bus.b         = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.state", bus.state, 2'd0);
    chk("rst.out_valid", bus.out_valid, 1'b0);
    chk("rst.result", bus.result, 32'h0);
    chk("rst.zero", bus.zero, 1'b0);
    chk("rst.dbz", bus.div_by_zero, 1'b0);
    chk("rst.ill", bus.illegal, 1'b0);
    chk("rst.busy", bus.busy, 1'b0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", bus.in_ready, 1'b1);

    run_op("sub_5_7",   3'b010, 6'b100010, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    run_op("mul_big",   3'b010, 6'b011000, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b0, 1'b0, 33);
    run_op("div_by_0",  3'b010, 6'b011010, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
    run_op("div_100_7", 3'b010, 6'b011010, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
    run_op("slt_op001", 3'b001, 6'b000000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    run_op("ill_op111", 3'b111, 6'b000000, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1);
    run_op("add_fn",    3'b010, 6'b100000, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1);
    run_op("add_wrap",  3'b000, 6'b111111, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b0, 1);
    run_op("and_op100", 3'b100, 6'b000000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1);
    run_op("or_fn",     3'b010, 6'b100101, 32'h0000_F0F0, 32'h0000_0F00, 32'h0000_FFF0, 1'b0, 1'b0, 1);
    run_op("slt_fn_neg",3'b010, 6'b101010, 32'd2, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1);
    run_op("nop",       3'b010, 6'b000000, 32'd5, 32'd6, 32'd0, 1'b0, 1'b0, 1);
    run_op("ill_fn",    3'b010, 6'b111111, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1, 1);
    run_op("mul_7_6",   3'b010, 6'b011000, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 33);
    run_op("mul_wrap",  3'b010, 6'b011000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 33);
    run_op("div_max",   3'b010, 6'b011010, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1'b0, 1'b0, 33);
    run_op("div_small", 3'b010, 6'b011010, 32'd7, 32'd100, 32'd0, 1'b0, 1'b0, 33);

    // Backpressure: hold result for 5 cycles, then consume and accept together.
    bus.out_ready = 1'b0;
    bus.aluop = 3'b010; bus.func = 6'b100000; bus.a = 32'd10; bus.b = 32'd20;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp.out_valid", bus.out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.hold_result", bus.result, 32'd30);
      chk("bp.hold_in_ready", bus.in_ready, 1'b0);
      chk("bp.hold_valid", bus.out_valid, 1'b1);
    end
    bus.a = 32'd1; bus.b = 32'd1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("bp.in_ready_done", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp.b2b_valid", bus.out_valid, 1'b1);
    chk("bp.b2b_result", bus.result, 32'd2);
    @(posedge clk); #1;
    chk("bp.b2b_consumed", bus.out_valid, 1'b0);

    // Reset partway through a divide.
    bus.aluop = 3'b010; bus.func = 6'b011010; bus.a = 32'd1000; bus.b = 32'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("rstdiv.busy_before", bus.busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstdiv.state_in_rst", bus.state, 2'd0);
    chk("rstdiv.valid_in_rst", bus.out_valid, 1'b0);
    chk("rstdiv.busy_in_rst", bus.busy, 1'b0);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("rstdiv.no_result", seen, 0);
    chk("rstdiv.state_idle", bus.state, 2'd0);
    run_op("add_after_rst", 3'b010, 6'b100000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning datapath width in bits (legal range 8..64).
REQ-002 The block SHALL have port CLK  input  1  rising-edge clock.
REQ-003 The block SHALL have port RST_N  input  1  asynchronous reset, active low.
REQ-004 The block SHALL have port IN_VALID  input  1  request present.
REQ-005 The block SHALL have port IN_READY  output  1  request accepted when IN_VALID&IN_READY at a rising edge.
REQ-006 The block SHALL have port ALUOP  input  3  operation class.
REQ-007 The block SHALL have port FUNCTION  input  6  R-type function field, used only when ALUOP=010.
REQ-008 The block SHALL have ports A and B  input  WIDTH each  operands.
REQ-009 The block SHALL have port OUT_VALID  output  1  result held valid.
REQ-010 The block SHALL have port OUT_READY  input  1  result consumed when OUT_VALID&OUT_READY at a rising edge.
REQ-011 The block SHALL have port RESULT  output  WIDTH  operation result.
REQ-012 The block SHALL have ports ZERO, DIV_BY_ZERO, ILLEGAL  output  1 each  status flags, valid with OUT_VALID.
REQ-013 The block SHALL have port BUSY  output  1  high in MUL or DIV state.

Function
REQ-014 Decode SHALL be: ALUOP=010 with FUNCTION 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 011000 MUL, 011010 DIV, 000000 NOP; ALUOP 000 ADD, 001 SLT, 100 AND, 011 OR.
REQ-015 Any other ALUOP, or ALUOP=010 with an unlisted FUNCTION, SHALL complete as single-cycle with RESULT=0, ILLEGAL=1.
REQ-016 ADD/SUB SHALL wrap modulo 2^WIDTH; SLT SHALL be signed two's complement, RESULT=1 or 0 zero-extended; NOP SHALL give RESULT=0, ILLEGAL=0.
REQ-017 MUL SHALL be iterative shift-add, unsigned, RESULT = low WIDTH bits of A*B.
REQ-018 DIV SHALL be iterative restoring, unsigned, RESULT = A/B quotient; remainder discarded.
REQ-019 B=0 on DIV SHALL skip iteration and complete in one cycle with RESULT all-ones, DIV_BY_ZERO=1.
REQ-020 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-021 IDLE: on accept, single-cycle ops and DIV-by-zero SHALL go to DONE; MUL SHALL go to MUL; DIV SHALL go to DIV; operands and decoded op SHALL be registered at accept.
REQ-022 MUL/DIV SHALL perform one step per clock with a counter 0..WIDTH-1, then enter DONE after exactly WIDTH steps.
REQ-023 Latency from accept edge to OUT_VALID high SHALL be 1 edge for single-cycle ops and WIDTH+1 edges for MUL/DIV.
REQ-024 DONE: OUT_VALID=1; RESULT and flags SHALL stay stable until consumed.
REQ-025 IN_READY SHALL be 1 in IDLE, OUT_READY in DONE, and 0 in MUL/DIV.
REQ-026 In DONE with OUT_READY=1: with a simultaneous accepted request, the block SHALL start it with no idle cycle; otherwise it SHALL return to IDLE.
REQ-027 ZERO SHALL be 1 iff RESULT=0, including illegal/NOP results.
REQ-028 IN_VALID, ALUOP, FUNCTION, A, B changes during MUL/DIV SHALL have no effect.

Reset
REQ-029 RST_N low SHALL immediately force state IDLE, counter 0, OUT_VALID=0, RESULT=0, ZERO=0, DIV_BY_ZERO=0, ILLEGAL=0, BUSY=0, IN_READY=1 after release.
REQ-030 Reset asserted mid-MUL/DIV SHALL abort the operation with no result ever presented.

Verification
REQ-031 WIDTH=32, ALUOP=010 FUNCTION=100010 A=5 B=7, OUT_READY=1 -> one edge later OUT_VALID=1, RESULT=0xFFFFFFFE, ZERO=0.
REQ-032 ALUOP=010 FUNCTION=011000 A=0x10000 B=0x10001 -> BUSY for 32 cycles, OUT_VALID on edge 33, RESULT=0x00010000.
REQ-033 ALUOP=010 FUNCTION=011010 A=100 B=0 -> one edge later RESULT=0xFFFFFFFF, DIV_BY_ZERO=1; A=100 B=7 -> RESULT=14 after 33 edges.
REQ-034 ALUOP=001 A=0xFFFFFFFF B=1 -> RESULT=1; ALUOP=111 -> RESULT=0, ILLEGAL=1, ZERO=1.
REQ-035 OUT_READY=0 for 5 cycles in DONE -> RESULT stable, IN_READY=0; then OUT_READY=1 with new IN_VALID -> new request accepted same edge.
REQ-036 RST_N pulsed low at step 10 of a DIV -> OUT_VALID stays 0, state IDLE, next ADD 2+3 returns 5 after one edge.
